// File: rtl/oms_pkg.sv
// ---------------------------------------------------------------------------
// oms_pkg
// Shared definitions for the odd-multiple-storage (OMS) LUT multiplier family.
//   - oms_state_t  : sequencer states of the clocked multiplier
//   - digit helpers: LUT depth, LUT index width and shift-amount width for an
//                    L-bit digit, usable in localparam expressions
// No ports (package).
// ---------------------------------------------------------------------------
package oms_pkg;

    typedef enum logic [2:0] {
        EMPTY,
        FILL,
        IDLE,
        BUSY,
        HOLD
    } oms_state_t;

    localparam int OMS_DEFAULT_L = 4;

    // Number of odd multiples stored for an l-bit digit: 1A, 3A, ..., (2^l-1)A.
    function automatic int oms_lut_depth(input int l);
        return 1 << (l - 1);
    endfunction

    // Index into the odd-multiple LUT; clamped to 1 bit for the degenerate l=1.
    function automatic int oms_idx_w(input int l);
        return (l > 1) ? (l - 1) : 1;
    endfunction

    // Width of the trailing-zero count of an l-bit digit.
    function automatic int oms_shift_w(input int l);
        return (l > 1) ? $clog2(l) : 1;
    endfunction

endpackage

// File: rtl/oms_digit_decode.sv
// ---------------------------------------------------------------------------
// oms_digit_decode
// Combinational split of an L-bit digit d into the form d = odd << shift, so
// that d*A can be read from an odd-multiple LUT and shifted.
// Ports:
//   digit  in  L     digit to decode
//   zero   out 1     digit is zero (contributes nothing)
//   idx    out L-1   LUT index of the odd part: (odd-1)/2
//   shift  out clog2(L) trailing zeros of the digit
// ---------------------------------------------------------------------------
module oms_digit_decode
    import oms_pkg::*;
#(
    parameter int L = OMS_DEFAULT_L,
    localparam int IW = oms_idx_w(L),
    localparam int SW = oms_shift_w(L)
) (
    input  logic [L-1:0]  digit,
    output logic          zero,
    output logic [IW-1:0] idx,
    output logic [SW-1:0] shift
);

    logic [L-1:0] odd;
    logic         found;

    // The lowest set bit gives the shift; the odd part's top bits are the index
    // because (odd-1)/2 simply drops the always-set LSB.
    always_comb begin
        zero  = (digit == '0);
        shift = '0;
        found = 1'b0;
        for (int i = 0; i < L; i++) begin
            if (!found && digit[i]) begin
                shift = SW'(i);
                found = 1'b1;
            end
        end
        odd = digit >> shift;
        idx = IW'(odd >> 1);
    end

endmodule

// File: rtl/oms_lut_mult_seq.sv
// ---------------------------------------------------------------------------
// oms_lut_mult_seq
// Sequential OMS LUT multiplier: product = x * A, one L-bit digit per cycle.
// The LUT holds only the odd multiples of A and is rebuilt by a one-adder
// fill sequencer whenever a new coefficient is loaded.
// Ports:
//   clk        in  1        clock, rising edge
//   reset_n    in  1        asynchronous active-low reset
//   coef_load  in  1        request to load coef and rebuild the LUT
//   coef       in  A_W      coefficient A
//   lut_ready  out 1        LUT valid for the current coefficient
//   in_valid   in  1        operand valid
//   in_ready   out 1        operand can be accepted
//   x          in  X_W      operand
//   out_valid  out 1        product valid
//   out_ready  in  1        consumer takes the product
//   product    out A_W+X_W  exact unsigned x*A
// ---------------------------------------------------------------------------
module oms_lut_mult_seq
    import oms_pkg::*;
#(
    parameter int A_W = 5,
    parameter int X_W = 8,
    parameter int L   = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               coef_load,
    input  logic [A_W-1:0]     coef,
    output logic               lut_ready,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [X_W-1:0]     x,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [A_W+X_W-1:0] product
);

    localparam int DIGITS = X_W / L;
    localparam int P_W    = A_W + X_W;
    localparam int DEPTH  = oms_lut_depth(L);
    localparam int IW     = oms_idx_w(L);
    localparam int SW     = oms_shift_w(L);
    localparam int E_W    = A_W + L;
    localparam int FC_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DC_W   = $clog2(DIGITS + 1);

    oms_state_t     state;
    oms_state_t     state_next;

    logic [A_W-1:0] coef_q;
    logic [E_W-1:0] lut [DEPTH];
    logic [E_W-1:0] fill_val;
    logic [FC_W-1:0] fill_cnt;
    logic [X_W-1:0] x_sh;
    logic [DC_W-1:0] dig_cnt;
    logic [P_W-1:0] acc;
    logic [P_W-1:0] contrib;

    logic           dig_zero;
    logic [IW-1:0]  dig_idx;
    logic [SW-1:0]  dig_shift;

    logic           load_accept;
    logic           in_fire;
    logic           fill_last;
    logic           digits_done;

    assign load_accept = coef_load && (state == EMPTY || state == IDLE || state == HOLD);
    assign in_fire     = in_valid && in_ready;
    assign fill_last   = (fill_cnt == FC_W'(DEPTH - 1));
    assign digits_done = (dig_cnt == DC_W'(DIGITS));

    oms_digit_decode #(.L(L)) u_decode (
        .digit (x_sh[L-1:0]),
        .zero  (dig_zero),
        .idx   (dig_idx),
        .shift (dig_shift)
    );

    // Odd multiple shifted back by its trailing zeros and by the digit weight.
    always_comb begin
        contrib = '0;
        if (!dig_zero) begin
            contrib = P_W'(lut[dig_idx]) << (32'(dig_shift) + 32'(dig_cnt) * 32'(L));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // A coefficient load wins over an operand in IDLE (in_ready is gated low)
    // and over the pending product in HOLD.
    always_comb begin
        state_next = state;
        lut_ready  = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            EMPTY: begin
                if (coef_load) state_next = FILL;
            end
            FILL: begin
                if (fill_last) state_next = IDLE;
            end
            IDLE: begin
                lut_ready = 1'b1;
                in_ready  = !coef_load;
                if (coef_load)     state_next = FILL;
                else if (in_valid) state_next = BUSY;
            end
            BUSY: begin
                lut_ready = 1'b1;
                if (digits_done) state_next = HOLD;
            end
            HOLD: begin
                lut_ready = 1'b1;
                out_valid = 1'b1;
                if (coef_load)      state_next = FILL;
                else if (out_ready) state_next = IDLE;
            end
            default: state_next = EMPTY;
        endcase
    end

    // Fill writes A, 3A, 5A, ... using a running sum stepped by 2A. BUSY runs
    // DIGITS accumulate cycles plus one cycle that moves the accumulator into
    // product, so product never shows a partial sum.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            coef_q   <= '0;
            fill_val <= '0;
            fill_cnt <= '0;
            x_sh     <= '0;
            dig_cnt  <= '0;
            acc      <= '0;
            product  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                lut[i] <= '0;
            end
        end else begin
            if (load_accept) begin
                coef_q   <= coef;
                fill_val <= E_W'(coef);
                fill_cnt <= '0;
            end else if (state == FILL) begin
                lut[fill_cnt] <= fill_val;
                fill_val      <= fill_val + (E_W'(coef_q) << 1);
                fill_cnt      <= fill_cnt + FC_W'(1);
            end

            if (in_fire) begin
                x_sh    <= x;
                acc     <= '0;
                dig_cnt <= '0;
            end else if (state == BUSY) begin
                if (digits_done) begin
                    product <= acc;
                end else begin
                    acc     <= acc + contrib;
                    x_sh    <= x_sh >> L;
                    dig_cnt <= dig_cnt + DC_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_oms_lut_mult_seq.sv
// ---------------------------------------------------------------------------
// tb_oms_lut_mult_seq
// Directed bench for oms_lut_mult_seq with default parameters. Expected
// products are pushed to a queue when an operand is accepted and popped when
// the product appears.
// ---------------------------------------------------------------------------
module tb_oms_lut_mult_seq;

    localparam int A_W    = 5;
    localparam int X_W    = 8;
    localparam int P_W    = A_W + X_W;
    localparam int DIGITS = 2;
    localparam int DEPTH  = 8;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           coef_load = 1'b0;
    logic [A_W-1:0] coef = '0;
    logic           lut_ready;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [X_W-1:0] x = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [P_W-1:0] product;

    int total = 0;
    int bad   = 0;
    int cur_a = 0;
    logic [P_W-1:0] sb_q [$];

    always #5 clk = ~clk;

    oms_lut_mult_seq #(.A_W(A_W), .X_W(X_W), .L(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .coef_load (coef_load),
        .coef      (coef),
        .lut_ready (lut_ready),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_lut_ready"}, 32'(lut_ready), 0);
        check({tag, "_in_ready"},  32'(in_ready),  0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_product"},   32'(product),   0);
    endtask

    // Called at the negedge after the load edge; LUT is ready 8 edges later.
    task automatic wait_fill();
        check("fill_lut_ready_low", 32'(lut_ready), 0);
        repeat (DEPTH - 1) @(posedge clk);
        @(negedge clk);
        check("fill_not_done_early", 32'(lut_ready), 0);
        @(posedge clk);
        @(negedge clk);
        check("fill_lut_ready_high", 32'(lut_ready), 1);
        check("fill_in_ready", 32'(in_ready), 1);
    endtask

    task automatic load_coef(input logic [A_W-1:0] c);
        coef_load = 1'b1;
        coef      = c;
        @(posedge clk);
        @(negedge clk);
        coef_load = 1'b0;
        cur_a     = int'(c);
        wait_fill();
    endtask

    task automatic accept_op(input logic [X_W-1:0] xv);
        int waited;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("in_ready_wait", 32'(in_ready), 1);
        in_valid = 1'b1;
        x        = xv;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        sb_q.push_back(P_W'(int'(xv) * cur_a));
    endtask

    task automatic finish_op(input int elapsed, input int hold);
        logic [P_W-1:0] exp;
        for (int k = elapsed + 1; k <= DIGITS + 1; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k < DIGITS + 1) check("out_valid_early", 32'(out_valid), 0);
            else                check("out_valid_rise",  32'(out_valid), 1);
        end
        check("sb_pending", 32'(sb_q.size() > 0), 1);
        exp = '0;
        if (sb_q.size() > 0) exp = sb_q.pop_front();
        check("product", 32'(product), 32'(exp));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_out_valid", 32'(out_valid), 1);
            check("hold_product",   32'(product),   32'(exp));
            check("hold_in_ready",  32'(in_ready),  0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("consumed_out_valid", 32'(out_valid), 0);
        check("consumed_in_ready",  32'(in_ready),  1);
        check("consumed_product_kept", 32'(product), 32'(exp));
    endtask

    initial begin
        logic [P_W-1:0] exp;

        repeat (2) @(negedge clk);
        check_all_zero("in_reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("after_reset");

        load_coef(5'd5);
        accept_op(8'hB7); finish_op(0, 0);
        accept_op(8'h00); finish_op(0, 0);
        accept_op(8'h80); finish_op(0, 0);

        // Single digits 1..15 read every LUT entry through both shift paths.
        for (int d = 1; d < 16; d++) begin
            accept_op(X_W'(d));
            finish_op(0, 0);
        end

        accept_op(8'h5A); finish_op(0, 4);

        // coef_load while BUSY must be ignored.
        accept_op(8'd20);
        coef_load = 1'b1;
        coef      = 5'd3;
        @(posedge clk);
        @(negedge clk);
        coef_load = 1'b0;
        check("busy_load_ignored_lut_ready", 32'(lut_ready), 1);
        check("busy_load_out_valid", 32'(out_valid), 0);
        finish_op(1, 0);

        // coef_load together with in_valid in IDLE: load wins.
        coef_load = 1'b1;
        coef      = 5'd3;
        in_valid  = 1'b1;
        x         = 8'd99;
        #1;
        check("idle_load_gates_in_ready", 32'(in_ready), 0);
        @(posedge clk);
        @(negedge clk);
        coef_load = 1'b0;
        in_valid  = 1'b0;
        cur_a     = 3;
        wait_fill();
        check("idle_load_no_output", 32'(out_valid), 0);
        check("idle_load_sb_empty", 32'(sb_q.size()), 0);
        accept_op(8'd10); finish_op(0, 0);

        // coef_load together with out_ready in HOLD: product consumed, FILL starts.
        accept_op(8'd7);
        repeat (DIGITS + 1) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("hold_load_out_valid", 32'(out_valid), 1);
        exp = '0;
        if (sb_q.size() > 0) exp = sb_q.pop_front();
        check("hold_load_product", 32'(product), 32'(exp));
        out_ready = 1'b1;
        coef_load = 1'b1;
        coef      = 5'd31;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        coef_load = 1'b0;
        cur_a     = 31;
        check("hold_load_valid_drop", 32'(out_valid), 0);
        check("hold_load_in_ready", 32'(in_ready), 0);
        wait_fill();
        accept_op(8'd255); finish_op(0, 0);

        load_coef(5'd0);
        accept_op(8'd200); finish_op(0, 0);

        // Asynchronous reset in the middle of BUSY discards the operand.
        load_coef(5'd5);
        accept_op(8'hB7); finish_op(0, 0);
        accept_op(8'd200);
        sb_q.delete();
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("post_reset_no_valid", 32'(out_valid), 0);
        end
        check("post_reset_lut_ready", 32'(lut_ready), 0);
        check("post_reset_in_ready", 32'(in_ready), 0);

        load_coef(5'd5);
        accept_op(8'hB7); finish_op(0, 0);
        check("sb_drained", 32'(sb_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
